calc_result_bcd: RTL and testbench



---
 rtl/calc_result_bcd.sv | 159 +++++++++++++++
 tb/tb_calc_result_bcd.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_bcd.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional two's-complement input handling is enabled by defining NEG_SIGN_EN.
module calc_result_bcd #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  err_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  err_out,
  output logic                  neg_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_cap_q, err_cap_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mag_c;

`ifdef NEG_SIGN_EN
  logic               neg_cap_q, neg_cap_d;
  logic               neg_q, neg_d;

  // Convert the magnitude; the sign is carried separately to neg_out.
  assign mag_c   = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
  assign neg_out = neg_q;
`else
  assign mag_c   = bin_in;
  assign neg_out = 1'b0;
`endif

  assign bcd_out = bcd_q;
  assign err_out = err_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Add-3 correction on every scratch digit that would overflow on doubling.
  always_comb begin
    adj_c = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    err_cap_d = err_cap_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef NEG_SIGN_EN
    neg_cap_d = neg_cap_q;
    neg_d     = neg_q;
`endif

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d   = mag_c;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          err_cap_d = err_in;
`ifdef NEG_SIGN_EN
          neg_cap_d = bin_in[WIDTH-1];
`endif
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = {adj_c[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Only completed digits ever reach the output register.
        bcd_d   = err_cap_q ? {BCD_W{1'b1}} : scratch_q;
        err_d   = err_cap_q;
`ifdef NEG_SIGN_EN
        neg_d   = neg_cap_q;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      err_cap_q <= 1'b0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      err_cap_q <= err_cap_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef NEG_SIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_cap_q <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      neg_cap_q <= neg_cap_d;
      neg_q     <= neg_d;
    end
  end
`endif

endmodule

// File: tb/tb_calc_result_bcd.sv
// Self-checking bench for calc_result_bcd: decimal-arithmetic reference model
// checked every cycle, plus directed scenarios with literal expected digits.
module tb_calc_result_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        err_in;
  logic [19:0] bcd_out;
  logic        err_out;
  logic        neg_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  calc_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .err_in(err_in),
    .bcd_out(bcd_out), .err_out(err_out), .neg_out(neg_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Transaction-level model: a conversion accepted at an edge finishes 17 edges later.
  logic [19:0] m_bcd = '0;
  logic        m_err = 1'b0;
  logic        m_neg = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  bit          pend = 1'b0;
  int          age = 0;
  logic [15:0] cap_bin = '0;
  logic        cap_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bcd = '0; m_err = 1'b0; m_neg = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      pend = 1'b0; age = 0;
    end else begin
      m_done = 1'b0;
      if (pend) begin
        age++;
        m_busy = (age < 16);
        if (age == 17) begin
          int unsigned mag;
          logic neg;
          mag = int'(cap_bin);
          neg = 1'b0;
`ifdef NEG_SIGN_EN
          if (cap_bin[15]) begin
            mag = 65536 - int'(cap_bin);
            neg = 1'b1;
          end
`endif
          m_bcd  = cap_err ? 20'hFFFFF : to_bcd(mag);
          m_err  = cap_err;
          m_neg  = neg;
          m_done = 1'b1;
          pend   = 1'b0;
        end
      end else if (start) begin
        pend = 1'b1; age = 0; cap_bin = bin_in; cap_err = err_in; m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd_out", {12'b0, bcd_out}, {12'b0, m_bcd});
      check("err_out", {31'b0, err_out}, {31'b0, m_err});
      check("neg_out", {31'b0, neg_out}, {31'b0, m_neg});
      check("busy",    {31'b0, busy},    {31'b0, m_busy});
      check("done",    {31'b0, done},    {31'b0, m_done});
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [15:0] b, input logic e, output int acc);
    bin_in = b;
    err_in = e;
    start  = 1'b1;
    tick();
    acc    = cyc;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_done: no done pulse within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    int s, t1, t2, dc0;
    rst = 1'b0; start = 1'b0; bin_in = '0; err_in = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    check("reset_bcd",  {12'b0, bcd_out}, 32'h0);
    check("reset_busy", {31'b0, busy},    32'h0);
    check("reset_done", {31'b0, done},    32'h0);

    // 120+60
    start_conv(16'd180, 1'b0, s);
    wait_done(t1);
    check("add_bcd",     {12'b0, bcd_out}, 32'h00180);
    check("add_err",     {31'b0, err_out}, 32'h0);
    check("add_latency", t1 - s,           32'd17);
    tick();

    // Back-to-back with start held high
    bin_in = 16'd7200; err_in = 1'b0; start = 1'b1;
    tick();
    bin_in = 16'hFFFF;
    wait_done(t1);
    check("b2b_first", {12'b0, bcd_out}, 32'h07200);
    wait_done(t2);
    start = 1'b0;
`ifdef NEG_SIGN_EN
    check("b2b_second", {12'b0, bcd_out}, 32'h00001);
    check("b2b_neg",    {31'b0, neg_out}, 32'h1);
`else
    check("b2b_second", {12'b0, bcd_out}, 32'h65535);
`endif
    check("b2b_period", t2 - t1, 32'd18);
    tick();

    // Divide by zero, then a clean conversion
    start_conv(16'd0, 1'b1, s);
    wait_done(t1);
    check("err_bcd", {12'b0, bcd_out}, 32'hFFFFF);
    check("err_flag", {31'b0, err_out}, 32'h1);
    tick();
    start_conv(16'd2, 1'b0, s);
    wait_done(t1);
    check("after_err_bcd",  {12'b0, bcd_out}, 32'h00002);
    check("after_err_flag", {31'b0, err_out}, 32'h0);
    tick();

    // Start mid-conversion is ignored
    dc0 = done_cnt;
    start_conv(16'd1234, 1'b0, s);
    repeat (5) tick();
    bin_in = 16'd999; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(t1);
    check("ignore_bcd", {12'b0, bcd_out}, 32'h01234);
    repeat (25) tick();
    check("ignore_one_done", done_cnt - dc0, 32'd1);

    // Reset in the middle of a conversion
    start_conv(16'd810, 1'b0, s);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("midrst_bcd",  {12'b0, bcd_out}, 32'h0);
    check("midrst_busy", {31'b0, busy},    32'h0);
    tick();
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (20) tick();
    check("midrst_no_done", done_cnt - dc0, 32'd0);
    start_conv(16'd810, 1'b0, s);
    wait_done(t1);
    check("post_rst_bcd", {12'b0, bcd_out}, 32'h00810);
    tick();

    // 18-45 as a 16-bit result, and the most negative value
    start_conv(16'hFFE5, 1'b0, s);
    wait_done(t1);
`ifdef NEG_SIGN_EN
    check("neg_bcd", {12'b0, bcd_out}, 32'h00027);
    check("neg_flag", {31'b0, neg_out}, 32'h1);
`else
    check("neg_bcd", {12'b0, bcd_out}, 32'h65509);
    check("neg_flag", {31'b0, neg_out}, 32'h0);
`endif
    tick();
    start_conv(16'h8000, 1'b0, s);
    wait_done(t1);
    check("min_bcd", {12'b0, bcd_out}, 32'h32768);
`ifdef NEG_SIGN_EN
    check("min_neg", {31'b0, neg_out}, 32'h1);
`else
    check("min_neg", {31'b0, neg_out}, 32'h0);
`endif
    repeat (3) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
